// File: rtl/vga_pkg.sv
// Shared constants and state encoding for the VGA pixel-write arbiter.
package vga_pkg;

   localparam int unsigned H_RES_320 = 320;
   localparam int unsigned V_RES_240 = 240;
   localparam int unsigned X_W       = 9;
   localparam int unsigned Y_W       = 8;
   localparam int unsigned COLOUR_W  = 3;

   typedef enum logic {
      IDLE,
      GRANT
   } arb_state_t;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Engine-side request/pixel bus and adapter-side pixel port of the plot arbiter.
interface vga_plot_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
);

   logic [NUM_REQ-1:0]                   req;
   logic [NUM_REQ-1:0]                   valid;
   logic [vga_pkg::X_W*NUM_REQ-1:0]      x_in;
   logic [vga_pkg::Y_W*NUM_REQ-1:0]      y_in;
   logic [vga_pkg::COLOUR_W*NUM_REQ-1:0] colour_in;
   logic [NUM_REQ-1:0]                   gnt;
   logic [vga_pkg::X_W-1:0]              x_out;
   logic [vga_pkg::Y_W-1:0]              y_out;
   logic [vga_pkg::COLOUR_W-1:0]         colour_out;
   logic                                 plot;

   modport master (
      output req, valid, x_in, y_in, colour_in,
      input  gnt, x_out, y_out, colour_out, plot
   );

   modport slave (
      input  req, valid, x_in, y_in, colour_in,
      output gnt, x_out, y_out, colour_out, plot
   );

endinterface

// File: rtl/vga_plot_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted req at or above rr_ptr, wrapping.
module rr_pick #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      rr_ptr,
   output logic [IW-1:0]      sel,
   output logic               any_req
);

   always_comb begin
      int unsigned idx;
      idx     = '0;
      sel     = '0;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            sel     = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin burst arbiter sharing the vga_adapter pixel-write port between engines.
// Optional range clipping of accepted pixels is enabled by defining VGA_PLOT_CLIP_EN.
module vga_plot_arbiter
   import vga_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 4,
   parameter  int unsigned MAX_BURST = 256,
   parameter  int unsigned H_RES     = H_RES_320,
   parameter  int unsigned V_RES     = V_RES_240,
   localparam int unsigned OW        = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   vga_plot_arbiter_if.slave    bus,
   output logic                 busy,
   output logic [OW-1:0]        owner,
   output logic [15:0]          clip_cnt
);

   localparam int unsigned BW = $clog2(MAX_BURST) + 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || H_RES > 512 || V_RES > 256) begin : g_param_check
      $error("vga_plot_arbiter: parameter out of range");
   end

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [OW-1:0]       owner_q, owner_d;
   logic [OW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
   logic                plot_q, plot_d;
   logic [X_W-1:0]      x_q, x_d;
   logic [Y_W-1:0]      y_q, y_d;
   logic [COLOUR_W-1:0] c_q, c_d;

   logic [OW-1:0]       sel;
   logic                any_req;
   logic                own_req, own_valid, others_req;
   logic                accept, burst_last, rel, clipped;
   logic [X_W-1:0]      px;
   logic [Y_W-1:0]      py;
   logic [COLOUR_W-1:0] pc;

   rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
      .req     (bus.req),
      .rr_ptr  (rr_ptr_q),
      .sel     (sel),
      .any_req (any_req)
   );

   assign own_req    = bus.req[owner_q];
   assign own_valid  = bus.valid[owner_q];
   // gnt_q is onehot(owner) while granted, so masking with it isolates competitors
   assign others_req = |(bus.req & ~gnt_q);
   assign px         = bus.x_in[owner_q*X_W +: X_W];
   assign py         = bus.y_in[owner_q*Y_W +: Y_W];
   assign pc         = bus.colour_in[owner_q*COLOUR_W +: COLOUR_W];
   assign accept     = (state_q == GRANT) && gnt_q[owner_q] && own_req && own_valid;
   assign burst_last = (burst_cnt_q == BW'(MAX_BURST - 1));
   assign rel        = (state_q == GRANT) &&
                       (!own_req || (accept && burst_last && others_req));

`ifdef VGA_PLOT_CLIP_EN
   logic [15:0] clip_q;

   assign clipped  = (32'(px) >= H_RES) || (32'(py) >= V_RES);
   assign clip_cnt = clip_q;

   always_ff @(posedge clk) begin
      if (reset)
         clip_q <= '0;
      else if (accept && clipped && clip_q != '1)
         clip_q <= clip_q + 1'b1;
   end
`else
   assign clipped  = 1'b0;
   assign clip_cnt = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (any_req) state_d = GRANT;
         GRANT:   if (rel)     state_d = IDLE;
         default:              state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      plot_d      = 1'b0;
      x_d         = x_q;
      y_d         = y_q;
      c_d         = c_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d       = '0;
               gnt_d[sel]  = 1'b1;
               owner_d     = sel;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (accept) begin
               // an uncontested burst simply restarts its count and keeps the port
               burst_cnt_d = (burst_last && !others_req) ? '0 : burst_cnt_q + 1'b1;
               if (!clipped) begin
                  plot_d = 1'b1;
                  x_d    = px;
                  y_d    = py;
                  c_d    = pc;
               end
            end
            if (rel) begin
               gnt_d    = '0;
               rr_ptr_d = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
         end
         default: gnt_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_q       <= '0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
         plot_q      <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         c_q         <= '0;
      end else begin
         gnt_q       <= gnt_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
         plot_q      <= plot_d;
         x_q         <= x_d;
         y_q         <= y_d;
         c_q         <= c_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.plot       = plot_q;
   assign bus.x_out      = x_q;
   assign bus.y_out      = y_q;
   assign bus.colour_out = c_q;
   assign busy           = (state_q == GRANT);
   assign owner          = owner_q;

endmodule
